// File: rtl/dmem_block_avg.sv
// Sums 2^len_log2 consecutive memory words from base and reports sum/avg; done N cycles after start (N+1 with
// DMEM_BLOCK_AVG_WRITEBACK_EN, which also writes avg to base+N); start is ignored while busy.
module dmem_block_avg #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [3:0]        len_log2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] avg,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = 11;

  // Completion is folded into the last read (or WB) edge, so S_FIN is never occupied.
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WB, S_FIN} state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] avg_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        len_q;

  logic [3:0]        len_eff;
  logic [CNT_W-1:0]  n_last;
  logic [DATA_W-1:0] sum_d;
  logic [DATA_W-1:0] avg_d;

  assign len_eff = (len_log2 > 4'd10) ? 4'd10 : len_log2;
  assign n_last  = CNT_W'(1) << len_q;
  assign sum_d   = sum_q + mem_rdata;
  assign avg_d   = sum_d >> len_q;

`ifdef DMEM_BLOCK_AVG_WRITEBACK_EN
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_q      <= '0;
      avg_q      <= '0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
`ifdef DMEM_BLOCK_AVG_WRITEBACK_EN
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_READ;
            busy_q     <= 1'b1;
            mem_addr_q <= base;
            sum_q      <= '0;
            cnt_q      <= CNT_W'(1);
            len_q      <= len_eff;
          end
        end
        S_READ: begin
          sum_q <= sum_d;
          if (cnt_q == n_last) begin
            avg_q <= avg_d;
`ifdef DMEM_BLOCK_AVG_WRITEBACK_EN
            // Address is base+N-1 here, so one more step lands on base+N.
            state_q     <= S_WB;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            mem_wdata_q <= avg_d;
`else
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end else begin
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
            cnt_q      <= cnt_q + CNT_W'(1);
          end
        end
`ifdef DMEM_BLOCK_AVG_WRITEBACK_EN
        S_WB: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          mem_we_q    <= 1'b0;
          mem_wdata_q <= '0;
        end
`endif
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign avg      = avg_q;
  assign mem_addr = mem_addr_q;
`ifdef DMEM_BLOCK_AVG_WRITEBACK_EN
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
`else
  assign mem_we    = 1'b0;
  assign mem_wdata = '0;
`endif

endmodule

// File: tb/tb_dmem_block_avg.sv
// Directed bench for dmem_block_avg with a negedge-sampled memory model and a result scoreboard.
module tb_dmem_block_avg;

  localparam int AW = 10;
  localparam int DW = 32;
`ifdef DMEM_BLOCK_AVG_WRITEBACK_EN
  localparam int WB = 1;
`else
  localparam int WB = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [3:0]    len_log2;
  logic          busy;
  logic          done;
  logic [DW-1:0] sum;
  logic [DW-1:0] avg;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  dmem_block_avg #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len_log2(len_log2),
    .busy(busy), .done(done), .sum(sum), .avg(avg), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] sum;
    logic [DW-1:0] avg;
    int            lat;
    logic [AW-1:0] wb_addr;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] mem [0:1023];
  logic [AW-1:0] addr_q[$];
  int            we_cnt;
  logic [AW-1:0] we_addr;
  logic [DW-1:0] we_data;
  int            n_chk;
  int            n_pass;

  // Memory samples address and write strobe on the falling edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] = mem_wdata;
      we_cnt  = we_cnt + 1;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
    if (busy === 1'b1 && mem_we !== 1'b1) addr_q.push_back(mem_addr);
    mem_rdata = mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic push_exp(input logic [AW-1:0] b, input logic [3:0] l);
    exp_t          e;
    int            eff;
    int            n;
    logic [AW-1:0] a;
    logic [DW-1:0] s;
    eff = (l > 4'd10) ? 10 : int'(l);
    n   = 1 << eff;
    a   = b;
    s   = '0;
    for (int i = 0; i < n; i++) begin
      s = s + mem[a];
      a = a + 10'd1;
    end
    e.sum     = s;
    e.avg     = s >> eff;
    e.lat     = n + WB;
    e.wb_addr = a;
    sb_q.push_back(e);
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [3:0] l);
    base     = b;
    len_log2 = l;
    start    = 1'b1;
    push_exp(b, l);
    addr_q.delete();
    we_cnt = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int c0);
    exp_t e;
    int   cyc;
    cyc = c0;
    while (done !== 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
    end
    if (done !== 1'b1) begin
      chk({tag, "_timeout"}, 64'(done), 64'd1);
      sb_q.delete();
      return;
    end
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_lat"},  64'(cyc),  64'(e.lat));
    chk({tag, "_sum"},  64'(sum),  64'(e.sum));
    chk({tag, "_avg"},  64'(avg),  64'(e.avg));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
`ifdef DMEM_BLOCK_AVG_WRITEBACK_EN
    chk({tag, "_we_cnt"},  64'(we_cnt),  64'd1);
    chk({tag, "_we_addr"}, 64'(we_addr), 64'(e.wb_addr));
    chk({tag, "_we_data"}, 64'(we_data), 64'(e.avg));
`else
    chk({tag, "_we_cnt"}, 64'(we_cnt), 64'd0);
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_done"},  64'(done),      64'd0);
    chk({tag, "_sum"},   64'(sum),       64'd0);
    chk({tag, "_avg"},   64'(avg),       64'd0);
    chk({tag, "_we"},    64'(mem_we),    64'd0);
    chk({tag, "_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  initial begin
    int seen_done;
    n_chk    = 0;
    n_pass   = 0;
    we_cnt   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    base     = '0;
    len_log2 = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 7 + 3);
    for (int i = 0; i < 7; i++) mem[i] = 32'(i + 1);
    mem[7]    = 32'd12;
    mem[1023] = 32'd10;

    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Eight-word block from 0: 1..7,12.
    launch(10'd0, 4'd3);
    wait_done("blk8", 0);
    chk("blk8_sum_const", 64'(sum), 64'd40);
    chk("blk8_avg_const", 64'(avg), 64'd5);
`ifdef DMEM_BLOCK_AVG_WRITEBACK_EN
    chk("blk8_mem8", 64'(mem[8]), 64'd5);
`endif
    tick();
    chk("pulse_done_low", 64'(done), 64'd0);
    chk("pulse_busy_low", 64'(busy), 64'd0);
    chk("hold_sum",       64'(sum),  64'd40);
    chk("hold_avg",       64'(avg),  64'd5);

    // Address wrap at the top of memory.
    launch(10'd1023, 4'd1);
    wait_done("wrap", 0);
    chk("wrap_nread", 64'(addr_q.size()), 64'd2);
    if (addr_q.size() >= 2) begin
      chk("wrap_addr0", 64'(addr_q[0]), 64'd1023);
      chk("wrap_addr1", 64'(addr_q[1]), 64'd0);
    end
    chk("wrap_sum_const", 64'(sum), 64'd11);
    chk("wrap_avg_const", 64'(avg), 64'd5);

    // Single-word block.
    launch(10'd5, 4'd0);
    wait_done("n1", 0);
    chk("n1_avg_const", 64'(avg), 64'(mem[5]));

    // Start raised at T3 and held through the done cycle.
    launch(10'd0, 4'd3);
    tick();
    tick();
    start    = 1'b1;
    base     = 10'd200;
    len_log2 = 4'd2;
    wait_done("busy_start", 2);
    push_exp(10'd200, 4'd2);
    addr_q.delete();
    we_cnt = 0;
    tick();
    start = 1'b0;
    chk("restart_busy", 64'(busy), 64'd1);
    chk("restart_done", 64'(done), 64'd0);
    wait_done("held_start", 0);

    // Reset at T4 of an eight-word run.
    launch(10'd0, 4'd3);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk_zero("abort");
    rst_n = 1'b1;
    sb_q.delete();
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) seen_done++;
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);
    chk("abort_no_we",   64'(we_cnt),    64'd0);
    chk("abort_idle",    64'(busy),      64'd0);

    // len_log2 above 10 clamps to a 1024-word block.
    launch(10'd0, 4'd15);
    wait_done("len15", 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_block_avg.md
DMEM_BLOCK_AVG -- requirements
Module: dmem_block_avg

Interface
REQ-001 Parameter ADDR_W, default 10, memory word-address width (1024 words).
REQ-002 Parameter DATA_W, default 32, memory word width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request a block operation; sampled only when busy=0.
REQ-006 base  input  ADDR_W  first word address; sampled with accepted start.
REQ-007 len_log2  input  4  block length N=2^len_log2 words; 0..10 legal; 11..15 clamp to 10; sampled with accepted start.
REQ-008 busy  output  1  high from the edge after an accepted start until the edge that raises done.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 sum  output  DATA_W  modulo-2^DATA_W sum of the N words read.
REQ-011 avg  output  DATA_W  sum logically shifted right by len_log2 (after clamp).
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_addr  output  ADDR_W  memory word address.
REQ-014 mem_wdata  output  DATA_W  memory write data.
REQ-015 mem_rdata  input  DATA_W  memory read data, valid before the posedge following the cycle mem_addr is driven (memory samples on negedge).

Function
REQ-016 FSM states: IDLE, READ, WB, FIN; all outputs are registered.
REQ-017 IDLE: start=1 at edge T0 -> mem_addr<=base, sum<=0, issue counter<=1, state<=READ, busy<=1.
REQ-018 READ: at each edge Tk (k=1..N), mem_rdata (word base+k-1) is added into sum; for k<N, mem_addr<=mem_addr+1.
REQ-019 Address increment wraps modulo 2^ADDR_W (base=1023, N=2 reads 1023 then 0).
REQ-020 At T(N): with writeback disabled, state<=FIN path: done<=1, busy<=0, state<=IDLE at the same edge.
REQ-021 done high exactly one cycle; sum and avg valid while done=1 and held until next accepted start.
REQ-022 Latency: done rises at T(N) (N cycles after start edge) without writeback, T(N+1) with writeback.
REQ-023 mem_we=0 and mem_wdata=0 in all cycles except the WB cycle.
REQ-024 start while busy=1 is ignored with no side effect; start during the done cycle is accepted (busy=0).
REQ-025 avg updates combinationally-free: registered at the same edge as the final sum update.
REQ-026 len_log2=0 (N=1): single read, done at T1, avg=sum.

Reset
REQ-027 rst_n=0 at a posedge: state<=IDLE, busy=0, done=0, sum=0, avg=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-028 Reset mid-operation aborts immediately; no write is issued; no done pulse follows.

Configuration
REQ-029 Macro DMEM_BLOCK_AVG_WRITEBACK_EN: when defined, T(N) enters WB; WB cycle drives mem_we=1, mem_addr=base+N (mod 2^ADDR_W), mem_wdata=final avg; at T(N+1) done<=1, busy<=0, mem_we<=0, state<=IDLE.
REQ-030 Without DMEM_BLOCK_AVG_WRITEBACK_EN: WB state absent, mem_we tied 0, mem_wdata tied 0.

Verification
REQ-031 Memory words 0..7 = 1,2,3,4,5,6,7,12; start, base=0, len_log2=3 -> done at T8, sum=40, avg=5.
REQ-032 Same with DMEM_BLOCK_AVG_WRITEBACK_EN -> single write cycle mem_we=1, addr=8, wdata=5; done at T9; memory[8]=5.
REQ-033 base=1023, len_log2=1, mem[1023]=10, mem[0]=1 -> addresses 1023,0; sum=11, avg=5.
REQ-034 start pulsed on T3 of an active run -> ignored; result and timing unchanged; start held through done cycle -> new run begins at that edge.
REQ-035 rst_n=0 at T4 of an 8-word run -> all outputs zero next cycle, no done, no mem_we.
REQ-036 len_log2=15 -> treated as 10: 1024 reads, done at T1024, avg=sum>>10.
